// File: rtl/regfile_pkg.sv
// Shared register-file types: widths, register count and the writeback entry
// format used by the write arbiter and the register file itself.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-push / one-pop in-order writeback queue. Push port 0 is always the older
// entry; port 1 is only used together with port 0.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push0,
    input  wb_entry_t                    i_entry0,
    input  logic                         i_push1,
    input  wb_entry_t                    i_entry1,
    input  logic                         i_pop,
    output wb_entry_t                    o_head,
    output logic [DEPTH-1:0]             o_ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] o_ent_dest,
    output logic [CNT_W-1:0]             o_count
);

    wb_entry_t          r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   w_wr_ptr1;
    logic [1:0]         w_num_push;

    assign w_wr_ptr1  = r_wr_ptr + PTR_W'(1);
    assign w_num_push = {1'b0, i_push0} + {1'b0, i_push1};

    // NOTE: the entry storage is deliberately not reset; emptiness is tracked by
    // r_valid/r_count, so resetting the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (i_push0) r_mem[r_wr_ptr]  <= i_entry0;
        if (i_push1) r_mem[w_wr_ptr1] <= i_entry1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pushed slots are free by construction, so they never alias the popped head.
            if (i_pop)   r_valid[r_rd_ptr]  <= 1'b0;
            if (i_push0) r_valid[r_wr_ptr]  <= 1'b1;
            if (i_push1) r_valid[w_wr_ptr1] <= 1'b1;
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_num_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
            r_count  <= r_count + CNT_W'(w_num_push) - CNT_W'(i_pop);
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_ent_valid = r_valid;
    assign o_count     = r_count;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_dest[i] = r_mem[i].dest;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-side front end of the register file: arbitrates ALU and load writebacks
// into an in-order queue drained one entry per cycle, and exports a pending mask.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_dest,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_dest,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                rg_wrt_enable,
    output logic [ADDR_W-1:0]   rg_wrt_dest,
    output logic [DATA_W-1:0]   rg_wrt_data,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [CNT_W-1:0]    count
);

    logic [CNT_W-1:0]             w_count;
    logic [CNT_W-1:0]             w_free;
    logic                         w_mem_push;
    logic                         w_alu_push;
    logic                         w_pop;
    wb_entry_t                    w_mem_entry;
    wb_entry_t                    w_alu_entry;
    wb_entry_t                    w_entry0;
    wb_entry_t                    w_head;
    logic [DEPTH-1:0]             w_ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] w_ent_dest;

    // Free space ignores a same-cycle pop, keeping ready off the drain path.
    assign w_free    = CNT_W'(DEPTH) - w_count;
    assign mem_ready = (w_free >= CNT_W'(1));
    assign alu_ready = (w_free >= CNT_W'(2)) || ((w_free == CNT_W'(1)) && !mem_valid);

    // r0 writes complete the handshake but are dropped here.
    assign w_mem_push = mem_valid && mem_ready && (mem_dest != '0);
    assign w_alu_push = alu_valid && alu_ready && (alu_dest != '0);

    assign w_mem_entry = '{dest: mem_dest, data: mem_data};
    assign w_alu_entry = '{dest: alu_dest, data: alu_data};
    assign w_entry0    = w_mem_push ? w_mem_entry : w_alu_entry;
    assign w_pop       = (w_count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push0     (w_mem_push || w_alu_push),
        .i_entry0    (w_entry0),
        .i_push1     (w_mem_push && w_alu_push),
        .i_entry1    (w_alu_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_ent_valid (w_ent_valid),
        .o_ent_dest  (w_ent_dest),
        .o_count     (w_count)
    );

    assign rg_wrt_enable = w_pop;
    assign rg_wrt_dest   = w_pop ? w_head.dest : '0;
    assign rg_wrt_data   = w_pop ? w_head.data : '0;
    assign count         = w_count;

    // NOTE: the mask is cleared before the loop so every path assigns it and
    // no latch is inferred.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_valid[i]) pending_mask |= reg_onehot(w_ent_dest[i]);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: hand-computed vectors plus a small
// queue model for sustained dual-producer traffic.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                alu_valid = 1'b0;
    logic                alu_ready;
    logic [ADDR_W-1:0]   alu_dest = '0;
    logic [DATA_W-1:0]   alu_data = '0;
    logic                mem_valid = 1'b0;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_dest = '0;
    logic [DATA_W-1:0]   mem_data = '0;
    logic                rg_wrt_enable;
    logic [ADDR_W-1:0]   rg_wrt_dest;
    logic [DATA_W-1:0]   rg_wrt_data;
    logic [NUM_REGS-1:0] pending_mask;
    logic [2:0]          count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_entry_t commit_log[$];
    wb_entry_t exp_log[$];
    wb_entry_t pend[$];

    regfile_write_arbiter #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_dest      (alu_dest),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_dest      (mem_dest),
        .mem_data      (mem_data),
        .rg_wrt_enable (rg_wrt_enable),
        .rg_wrt_dest   (rg_wrt_dest),
        .rg_wrt_data   (rg_wrt_data),
        .pending_mask  (pending_mask),
        .count         (count)
    );

    always #5 clk = ~clk;

    // A write visible at the falling edge is captured by the register file on the next rising edge.
    always @(negedge clk) begin
        if (rst && rg_wrt_enable) commit_log.push_back('{dest: rg_wrt_dest, data: rg_wrt_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_log(input string tag);
        check({tag, " log size"}, 32'(commit_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < commit_log.size(); i++) begin
            check($sformatf("%s commit %0d", tag, i), 32'(commit_log[i]), 32'(exp_log[i]));
        end
        commit_log.delete();
        exp_log.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, " count"},     32'(count),         0);
        check({tag, " wr_en"},     32'(rg_wrt_enable), 0);
        check({tag, " wr_dest"},   32'(rg_wrt_dest),   0);
        check({tag, " wr_data"},   32'(rg_wrt_data),   0);
        check({tag, " mask"},      32'(pending_mask),  0);
        check({tag, " mem_ready"}, 32'(mem_ready),     1);
        check({tag, " alu_ready"}, 32'(alu_ready),     1);
    endtask

    initial begin
        logic [2:0]  free;
        logic        exp_m, exp_a;
        logic [7:0]  exp_mask;
        int          k, j;
        logic [ADDR_W-1:0] md, ad;
        logic [DATA_W-1:0] mdat, adat;

        // Power-on reset
        #12;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_idle("post-release");

        // Single ALU write r3 = 0x1234
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h1234;
        #1;
        check("single alu_ready", 32'(alu_ready), 1);
        tick();
        alu_valid = 1'b0;
        check("single count",   32'(count),         1);
        check("single wr_en",   32'(rg_wrt_enable), 1);
        check("single wr_dest", 32'(rg_wrt_dest),   3);
        check("single wr_data", 32'(rg_wrt_data),   32'h1234);
        check("single mask",    32'(pending_mask),  32'h08);
        tick();
        check("single wr_en off", 32'(rg_wrt_enable), 0);
        check("single mask off",  32'(pending_mask),  0);
        exp_log.push_back('{dest: 3'd3, data: 16'h1234});
        compare_log("single");

        // Simultaneous mem r5 = 0xAAAA and ALU r5 = 0x5555
        mem_valid = 1'b1; mem_dest = 3'd5; mem_data = 16'hAAAA;
        alu_valid = 1'b1; alu_dest = 3'd5; alu_data = 16'h5555;
        #1;
        check("dual mem_ready", 32'(mem_ready), 1);
        check("dual alu_ready", 32'(alu_ready), 1);
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        check("dual count0", 32'(count),        2);
        check("dual data0",  32'(rg_wrt_data),  32'hAAAA);
        check("dual mask0",  32'(pending_mask), 32'h20);
        tick();
        check("dual count1", 32'(count),        1);
        check("dual data1",  32'(rg_wrt_data),  32'h5555);
        check("dual mask1",  32'(pending_mask), 32'h20);
        tick();
        check("dual mask2",  32'(pending_mask), 0);
        exp_log.push_back('{dest: 3'd5, data: 16'hAAAA});
        exp_log.push_back('{dest: 3'd5, data: 16'h5555});
        compare_log("dual");

        // Fill to count=3, then one free slot with both producers valid
        mem_valid = 1'b1; mem_dest = 3'd1; mem_data = 16'h1111;
        alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'h2222;
        tick();
        check("fill count a", 32'(count), 2);
        mem_dest = 3'd3; mem_data = 16'h3333;
        alu_dest = 3'd4; alu_data = 16'h4444;
        #1;
        check("fill alu_ready free2", 32'(alu_ready), 1);
        tick();
        check("fill count b", 32'(count), 3);
        mem_dest = 3'd6; mem_data = 16'h6666;
        alu_dest = 3'd7; alu_data = 16'h7777;
        #1;
        check("free1 mem_ready", 32'(mem_ready), 1);
        check("free1 alu_ready", 32'(alu_ready), 0);
        tick();
        mem_valid = 1'b0;
        check("free1 count c", 32'(count), 3);
        #1;
        check("free1 alu_ready solo", 32'(alu_ready), 1);
        tick();
        alu_valid = 1'b0;
        check("free1 count d", 32'(count), 3);
        for (int i = 0; i < 3; i++) tick();
        check("fill drained", 32'(count), 0);
        exp_log.push_back('{dest: 3'd1, data: 16'h1111});
        exp_log.push_back('{dest: 3'd2, data: 16'h2222});
        exp_log.push_back('{dest: 3'd3, data: 16'h3333});
        exp_log.push_back('{dest: 3'd4, data: 16'h4444});
        exp_log.push_back('{dest: 3'd6, data: 16'h6666});
        exp_log.push_back('{dest: 3'd7, data: 16'h7777});
        compare_log("fill");

        // ALU write to r0 is handshaken and discarded
        alu_valid = 1'b1; alu_dest = 3'd0; alu_data = 16'hFFFF;
        #1;
        check("r0 alu_ready", 32'(alu_ready), 1);
        tick();
        alu_valid = 1'b0;
        check("r0 count", 32'(count),         0);
        check("r0 wr_en", 32'(rg_wrt_enable), 0);
        check("r0 mask",  32'(pending_mask),  0);
        tick();
        compare_log("r0");

        // Sustained dual traffic against a queue model
        k = 0; j = 0;
        pend.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            md = 3'((k * 3 + 1) % 8); mdat = 16'hA000 + 16'(k);
            ad = 3'((j * 5 + 2) % 8); adat = 16'h5000 + 16'(j);
            mem_valid = 1'b1; mem_dest = md; mem_data = mdat;
            alu_valid = 1'b1; alu_dest = ad; alu_data = adat;
            #1;
            free  = 3'd4 - 3'(pend.size());
            exp_m = (free >= 3'd1);
            exp_a = (free >= 3'd2);
            check($sformatf("sus mem_ready %0d", cyc), 32'(mem_ready), 32'(exp_m));
            check($sformatf("sus alu_ready %0d", cyc), 32'(alu_ready), 32'(exp_a));
            tick();
            if (pend.size() > 0) void'(pend.pop_front());
            if (exp_m) begin
                k++;
                if (md != 0) begin
                    pend.push_back('{dest: md, data: mdat});
                    exp_log.push_back('{dest: md, data: mdat});
                end
            end
            if (exp_a) begin
                j++;
                if (ad != 0) begin
                    pend.push_back('{dest: ad, data: adat});
                    exp_log.push_back('{dest: ad, data: adat});
                end
            end
            exp_mask = '0;
            foreach (pend[p]) exp_mask |= reg_onehot(pend[p].dest);
            check($sformatf("sus count %0d", cyc), 32'(count), 32'(pend.size()));
            check($sformatf("sus mask %0d", cyc),  32'(pending_mask), 32'(exp_mask));
            if (pend.size() > 0)
                check($sformatf("sus head %0d", cyc),
                      32'({rg_wrt_dest, rg_wrt_data}), 32'(pend[0]));
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("sus drained", 32'(count), 0);
        compare_log("sustained");

        // Asynchronous reset with three entries queued
        mem_valid = 1'b1; mem_dest = 3'd2; mem_data = 16'hBEEF;
        alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 16'hCAFE;
        tick();
        mem_dest = 3'd6; mem_data = 16'hD00D;
        alu_dest = 3'd7; alu_data = 16'hF00D;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        check("pre-reset count", 32'(count), 3);
        #2;
        rst = 1'b0;
        #1;
        check_idle("mid reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("after reset wr_en", 32'(rg_wrt_enable), 0);
        exp_log.push_back('{dest: 3'd2, data: 16'hBEEF});
        compare_log("reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
